// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port (i_*) and a data port (d_*) onto one
// shared single-port memory, with at most one transaction outstanding.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   i_req, i_addr        fetch read request (level) and byte address
//   i_rdata, i_ack       fetch read data and one-cycle completion pulse
//   d_rd, d_wr           data read / write request (level; both = write)
//   d_addr, d_wdata      data byte address and write data
//   d_rdata, d_ack       data read result and one-cycle completion pulse
//   stall                combinational pipeline hold
//   mem_req, mem_we      memory request (level) and write enable
//   mem_addr, mem_wdata  memory address and write data, stable during BUSY
//   mem_rdata, mem_ack   memory read data and one-cycle completion pulse
//   timeout_err          sticky flag, set when a transaction is aborted
//
// Parameters:
//   TIMEOUT   BUSY cycles without mem_ack before abort (1..255)
//   ERR_DATA  read data returned to the requester on abort
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t     state, state_nx;
  logic       last_grant_d;   // 1 = data port was served last, 0 = fetch
  logic [7:0] cnt;
  logic       d_req;
  logic       busy;
  logic       expire;
  logic       finish;

  assign d_req  = d_rd | d_wr;
  assign busy   = (state == BUSY_I) || (state == BUSY_D);
  // mem_ack takes priority over an expiring counter in the same cycle.
  assign expire = busy && !mem_ack && (cnt == 8'(TIMEOUT - 1));
  assign finish = busy && (mem_ack || expire);

  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        // On conflict the port not served last wins.
        if (d_req && (!i_req || !last_grant_d)) state_nx = BUSY_D;
        else if (i_req)                         state_nx = BUSY_I;
      end
      BUSY_I, BUSY_D: if (finish) state_nx = DONE;
      DONE:           state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      timeout_err  <= 1'b0;
      cnt          <= '0;
      last_grant_d <= 1'b0;
    end else begin
      mem_req <= (state_nx == BUSY_I) || (state_nx == BUSY_D);
      i_ack   <= (state == BUSY_I) && finish;
      d_ack   <= (state == BUSY_D) && finish;

      if (state == IDLE && state_nx == BUSY_D) begin
        cnt       <= '0;
        mem_we    <= d_wr;
        mem_addr  <= d_addr;
        mem_wdata <= d_wr ? d_wdata : '0;
      end else if (state == IDLE && state_nx == BUSY_I) begin
        cnt       <= '0;
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
      end else if (finish) begin
        last_grant_d <= (state == BUSY_D);
        if (expire) timeout_err <= 1'b1;
        if (state == BUSY_I)
          i_rdata <= expire ? ERR_DATA : mem_rdata;
        else
          // Writes return zero rather than whatever the memory drives.
          d_rdata <= expire ? ERR_DATA : (mem_we ? '0 : mem_rdata);
      end else if (busy) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_rd, d_wr;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ack;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        timeout_err;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  mem_arbiter #(.TIMEOUT(4), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acks", {30'd0, i_ack, d_ack}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_terr", 32'(timeout_err), 0);
    reset = 1'b0;

    // Fetch alone: request in cycle 0, ack from memory in cycle 2, i_ack in 3.
    i_req = 1'b1; i_addr = 32'h40; #1;
    chk("f_stall_req", 32'(stall), 1);
    chk("f_mem_req_c0", 32'(mem_req), 0);
    tick();
    chk("f_mem_req_c1", 32'(mem_req), 1);
    chk("f_mem_addr", mem_addr, 32'h40);
    chk("f_mem_we", 32'(mem_we), 0);
    chk("f_mem_wdata", mem_wdata, 0);
    chk("f_i_ack_c1", 32'(i_ack), 0);
    tick();
    chk("f_mem_req_c2", 32'(mem_req), 1);
    mem_ack = 1'b1; mem_rdata = 32'h8C22_0010;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h1111_1111;
    chk("f_i_ack_c3", 32'(i_ack), 1);
    chk("f_i_rdata", i_rdata, 32'h8C22_0010);
    chk("f_mem_req_c3", 32'(mem_req), 0);
    chk("f_stall_ack", 32'(stall), 0);
    i_req = 1'b0;
    tick();
    chk("f_i_ack_c4", 32'(i_ack), 0);
    chk("f_i_rdata_hold", i_rdata, 32'h8C22_0010);
    chk("f_stall_after", 32'(stall), 0);

    // First conflict after reset: data wins, then fetch.
    i_req = 1'b1; i_addr = 32'h100; d_rd = 1'b1; d_addr = 32'h200;
    tick();
    chk("c1_first_addr", mem_addr, 32'h200);
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
    tick();
    mem_ack = 1'b0;
    chk("c1_d_ack", 32'(d_ack), 1);
    chk("c1_i_ack_quiet", 32'(i_ack), 0);
    chk("c1_d_rdata", d_rdata, 32'hAAAA_0001);
    chk("c1_stall_i", 32'(stall), 1);
    d_rd = 1'b0;
    tick();
    chk("c1_done_idle_req", 32'(mem_req), 0);
    tick();
    chk("c1_second_req", 32'(mem_req), 1);
    chk("c1_second_addr", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'h5555_0002;
    tick();
    mem_ack = 1'b0;
    chk("c1_i_ack", 32'(i_ack), 1);
    chk("c1_i_rdata", i_rdata, 32'h5555_0002);
    chk("c1_d_rdata_hold", d_rdata, 32'hAAAA_0001);
    i_req = 1'b0;
    tick();

    // Write with d_wdata changing mid-transaction; mem_wdata must not follow.
    d_wr = 1'b1; d_addr = 32'h10; d_wdata = 32'h1234_5678;
    tick();
    chk("w_mem_we", 32'(mem_we), 1);
    chk("w_mem_addr", mem_addr, 32'h10);
    chk("w_mem_wdata_b1", mem_wdata, 32'h1234_5678);
    d_wdata = 32'hFFFF_FFFF; d_addr = 32'h99;
    tick();
    chk("w_mem_wdata_b2", mem_wdata, 32'h1234_5678);
    chk("w_mem_addr_b2", mem_addr, 32'h10);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    chk("w_d_ack", 32'(d_ack), 1);
    chk("w_d_rdata_zero", d_rdata, 0);
    d_wr = 1'b0;
    tick();

    // Data was served last, so this conflict grants fetch first.
    i_req = 1'b1; i_addr = 32'h300; d_rd = 1'b1; d_wr = 1'b1;
    d_addr = 32'h400; d_wdata = 32'h0000_00AB;
    tick();
    chk("c2_first_addr", mem_addr, 32'h300);
    chk("c2_first_we", 32'(mem_we), 0);
    mem_ack = 1'b1; mem_rdata = 32'h7777_0003;
    tick();
    mem_ack = 1'b0;
    chk("c2_i_ack", 32'(i_ack), 1);
    i_req = 1'b0;
    tick(); tick();
    chk("c2_second_addr", mem_addr, 32'h400);
    chk("c2_rdwr_is_write", 32'(mem_we), 1);
    chk("c2_wdata", mem_wdata, 32'h0000_00AB);
    mem_ack = 1'b1; mem_rdata = 32'h8888_0004;
    tick();
    mem_ack = 1'b0;
    chk("c2_d_ack", 32'(d_ack), 1);
    chk("c2_d_rdata_zero", d_rdata, 0);
    d_rd = 1'b0; d_wr = 1'b0;
    tick();

    // mem_ack on the fourth BUSY cycle still completes normally.
    d_rd = 1'b1; d_addr = 32'h20;
    tick(); tick(); tick(); tick();
    chk("t4_mem_req_b4", 32'(mem_req), 1);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    tick();
    mem_ack = 1'b0;
    chk("t4_d_ack", 32'(d_ack), 1);
    chk("t4_d_rdata", d_rdata, 32'h0BAD_CAFE);
    chk("t4_no_err", 32'(timeout_err), 0);
    d_rd = 1'b0;
    tick();

    // Memory never answers: four BUSY cycles, then abort with ERR_DATA.
    d_rd = 1'b1; d_addr = 32'h30;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("to_mem_req_b%0d", i), 32'(mem_req), 1);
      chk($sformatf("to_d_ack_b%0d", i), 32'(d_ack), 0);
    end
    tick();
    chk("to_mem_req_done", 32'(mem_req), 0);
    chk("to_d_ack", 32'(d_ack), 1);
    chk("to_d_rdata", d_rdata, ERR);
    chk("to_err", 32'(timeout_err), 1);
    d_rd = 1'b0;
    tick();
    chk("to_err_sticky", 32'(timeout_err), 1);
    chk("to_d_ack_low", 32'(d_ack), 0);
    // Stray mem_ack in IDLE is ignored.
    mem_ack = 1'b1; mem_rdata = 32'h1234_0000;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_req", 32'(mem_req), 0);
    chk("idle_ack_no_ack", {30'd0, i_ack, d_ack}, 0);
    chk("idle_ack_d_rdata", d_rdata, ERR);

    // Reset while BUSY_I: no ack, late mem_ack ignored, everything cleared.
    i_req = 1'b1; i_addr = 32'h80;
    tick();
    chk("rb_busy", 32'(mem_req), 1);
    reset = 1'b1; i_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("rb_mem_req", 32'(mem_req), 0);
    chk("rb_mem_addr", mem_addr, 0);
    chk("rb_terr", 32'(timeout_err), 0);
    chk("rb_i_rdata", i_rdata, 0);
    chk("rb_d_rdata", d_rdata, 0);
    chk("rb_acks", {30'd0, i_ack, d_ack}, 0);
    mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
    tick();
    mem_ack = 1'b0;
    chk("rb_late_ack", {30'd0, i_ack, d_ack}, 0);
    chk("rb_late_req", 32'(mem_req), 0);
    tick();
    chk("rb_quiet_ack", {30'd0, i_ack, d_ack}, 0);
    chk("rb_quiet_rdata", i_rdata, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
